mem_ctrl: RTL and testbench

- Byte-serial memory controller directly downstream of the MEM stage; also serves instruction fetch (IF).
- Arbitrates the MEM stage's level-held load/store requests and IF's 32-bit fetch requests onto the single 8-bit synchronous RAM bus.
- Assembles or splits words little-endian and returns a one-cycle done pulse. MEM uses the pulse to drop mem_stall; IF uses it to drop its own stall.

---
 rtl/mem_ctrl_pkg.sv | 35 +++
 rtl/mem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module : mem_ctrl_pkg
// Brief  : Shared types and constants for the byte-serial memory controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [3:0] C_SIZE_WORD = 4'd0;
    localparam logic [3:0] C_SIZE_HALF = 4'd2;
    localparam logic [3:0] C_SIZE_BYTE = 4'd3;

    // Code 0 and any code outside the defined range store a full word.
    function automatic logic [2:0] store_bytes(input logic [3:0] code);
        if (code == C_SIZE_WORD || code >= 4'd4)
            return 3'd4;
        else
            return 3'(4'd4 - code);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module : mem_ctrl
// Brief  : Arbitrates IF fetches and MEM loads/stores onto an 8-bit RAM bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int READ_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [31:0]           if_data_o,
    output logic                  if_done_o,
    input  logic                  mem_r_req_i,
    input  logic                  mem_w_req_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_w_data_i,
    input  logic [3:0]            mem_buffer_pointer_i,
    output logic [31:0]           mem_r_data_o,
    output logic                  mem_done_o,
    input  logic [7:0]            ram_din_i,
    output logic [7:0]            ram_dout_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic                  ram_wr_o
);

    localparam logic [2:0] C_READ_LAST = 3'(READ_BYTES);

    state_t                r_state,   w_state;
    owner_t                r_owner,   w_owner;
    logic [2:0]            r_cnt,     w_cnt;
    logic [2:0]            r_len,     w_len;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr;
    logic [31:0]           r_wdata,   w_wdata;
    logic [31:0]           r_rbuf,    w_rbuf;
    logic [ADDR_WIDTH-1:0] r_ram_a,   w_ram_a;
    logic [7:0]            r_ram_dout, w_ram_dout;
    logic                  r_ram_wr,  w_ram_wr;
    logic                  r_if_done, w_if_done;
    logic                  r_mem_done, w_mem_done;
    logic [31:0]           r_if_data, w_if_data;
    logic [31:0]           r_mem_data, w_mem_data;
    logic [31:0]           w_wshift;

    assign w_wshift = r_wdata >> {r_cnt, 3'b000};

    always_comb begin
        w_state    = r_state;
        w_owner    = r_owner;
        w_cnt      = r_cnt;
        w_len      = r_len;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_rbuf     = r_rbuf;
        w_ram_a    = '0;
        w_ram_dout = '0;
        w_ram_wr   = 1'b0;
        w_if_done  = 1'b0;
        w_mem_done = 1'b0;
        w_if_data  = r_if_data;
        w_mem_data = r_mem_data;

        case (r_state)
            ST_IDLE: begin
                // Requesters still hold their request during the done cycle.
                if (!(r_if_done || r_mem_done)) begin
                    if (mem_w_req_i) begin
                        w_state    = ST_WRITE;
                        w_owner    = OWN_MEM;
                        w_addr     = mem_addr_i;
                        w_wdata    = mem_w_data_i;
                        w_len      = store_bytes(mem_buffer_pointer_i);
                        w_cnt      = 3'd1;
                        w_ram_a    = mem_addr_i;
                        w_ram_dout = mem_w_data_i[7:0];
                        w_ram_wr   = 1'b1;
                    end else if (mem_r_req_i) begin
                        w_state = ST_READ;
                        w_owner = OWN_MEM;
                        w_addr  = mem_addr_i;
                        w_cnt   = 3'd0;
                        w_ram_a = mem_addr_i;
                    end else if (if_req_i) begin
                        w_state = ST_READ;
                        w_owner = OWN_IF;
                        w_addr  = if_addr_i;
                        w_cnt   = 3'd0;
                        w_ram_a = if_addr_i;
                    end
                end
            end

            ST_WRITE: begin
                if (r_cnt < r_len) begin
                    w_ram_a    = r_addr + ADDR_WIDTH'(r_cnt);
                    w_ram_dout = w_wshift[7:0];
                    w_ram_wr   = 1'b1;
                    w_cnt      = r_cnt + 3'd1;
                end else begin
                    w_mem_done = 1'b1;
                    w_state    = ST_IDLE;
                    w_cnt      = 3'd0;
                end
            end

            ST_READ: begin
                if (r_owner == OWN_IF && !if_req_i) begin
                    w_state = ST_IDLE;
                    w_cnt   = 3'd0;
                end else begin
                    // r_cnt counts cycles since T+1; byte r_cnt-1 is on ram_din_i now.
                    if (r_cnt != 3'd0)
                        w_rbuf = {ram_din_i, r_rbuf[31:8]};
                    if (r_cnt < C_READ_LAST - 3'd1)
                        w_ram_a = r_addr + ADDR_WIDTH'(r_cnt + 3'd1);
                    w_cnt = r_cnt + 3'd1;
                    if (r_cnt == C_READ_LAST) begin
                        w_state = ST_IDLE;
                        w_cnt   = 3'd0;
                        if (r_owner == OWN_IF) begin
                            w_if_done = 1'b1;
                            w_if_data = w_rbuf;
                        end else begin
                            w_mem_done = 1'b1;
                            w_mem_data = w_rbuf;
                        end
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_cnt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_IF;
            r_cnt      <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rbuf     <= '0;
            r_ram_a    <= '0;
            r_ram_dout <= '0;
            r_ram_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_if_data  <= '0;
            r_mem_data <= '0;
        end else begin
            r_state    <= w_state;
            r_owner    <= w_owner;
            r_cnt      <= w_cnt;
            r_len      <= w_len;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_rbuf     <= w_rbuf;
            r_ram_a    <= w_ram_a;
            r_ram_dout <= w_ram_dout;
            r_ram_wr   <= w_ram_wr;
            r_if_done  <= w_if_done;
            r_mem_done <= w_mem_done;
            r_if_data  <= w_if_data;
            r_mem_data <= w_mem_data;
        end
    end

    assign if_data_o    = r_if_data;
    assign if_done_o    = r_if_done;
    assign mem_r_data_o = r_mem_data;
    assign mem_done_o   = r_mem_done;
    assign ram_dout_o   = r_ram_dout;
    assign ram_a_o      = r_ram_a;
    assign ram_wr_o     = r_ram_wr;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module : tb_mem_ctrl
// Brief  : Directed self-checking bench for mem_ctrl with a byte RAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_r_req_i;
    logic        mem_w_req_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_w_data_i;
    logic [3:0]  mem_buffer_pointer_i;
    logic [31:0] mem_r_data_o;
    logic        mem_done_o;
    logic [7:0]  ram_din_i;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;

    logic [7:0]  ram [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    mem_ctrl #(.ADDR_WIDTH(32), .READ_BYTES(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_req_i             (if_req_i),
        .if_addr_i            (if_addr_i),
        .if_data_o            (if_data_o),
        .if_done_o            (if_done_o),
        .mem_r_req_i          (mem_r_req_i),
        .mem_w_req_i          (mem_w_req_i),
        .mem_addr_i           (mem_addr_i),
        .mem_w_data_i         (mem_w_data_i),
        .mem_buffer_pointer_i (mem_buffer_pointer_i),
        .mem_r_data_o         (mem_r_data_o),
        .mem_done_o           (mem_done_o),
        .ram_din_i            (ram_din_i),
        .ram_dout_o           (ram_dout_o),
        .ram_a_o              (ram_a_o),
        .ram_wr_o             (ram_wr_o)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read byte appears one cycle after its address.
    always @(posedge clk) begin
        if (ram_wr_o)
            ram[ram_a_o[9:0]] <= ram_dout_o;
        ram_din_i <= ram[ram_a_o[9:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, ".a"},  ram_a_o, 32'h0);
        chk({tag, ".wr"}, {31'd0, ram_wr_o}, 32'h0);
        chk({tag, ".do"}, {24'd0, ram_dout_o}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[4] = 8'h13; ram[5] = 8'h00; ram[6] = 8'h00; ram[7] = 8'h00;
        ram[16] = 8'hEF; ram[17] = 8'hBE; ram[18] = 8'hAD; ram[19] = 8'hDE;
        ram[32] = 8'h93; ram[33] = 8'h00; ram[34] = 8'h50; ram[35] = 8'h00;

        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
        mem_r_req_i = 1'b0; mem_w_req_i = 1'b0; mem_addr_i = '0;
        mem_w_data_i = '0; mem_buffer_pointer_i = '0;

        // Reset then idle
        tick(); tick();
        chk_idle_bus("rst");
        chk("rst.ifd",  {31'd0, if_done_o}, 32'h0);
        chk("rst.memd", {31'd0, mem_done_o}, 32'h0);
        chk("rst.ifdat", if_data_o, 32'h0);
        chk("rst.memdat", mem_r_data_o, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle.wr", {31'd0, ram_wr_o}, 32'h0);
        end

        // IF fetch at 0x4
        if_req_i = 1'b1; if_addr_i = 32'h4;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("iff.a", ram_a_o, 32'h4 + 32'(k));
            chk("iff.wr", {31'd0, ram_wr_o}, 32'h0);
            chk("iff.done_early", {31'd0, if_done_o}, 32'h0);
        end
        tick();
        chk("iff.t5.done", {31'd0, if_done_o}, 32'h0);
        chk("iff.t5.a", ram_a_o, 32'h0);
        tick();
        chk("iff.t6.done", {31'd0, if_done_o}, 32'h1);
        chk("iff.t6.data", if_data_o, 32'h00000013);
        chk("iff.t6.memd", {31'd0, mem_done_o}, 32'h0);
        if_req_i = 1'b0;
        tick();
        chk("iff.t7.done", {31'd0, if_done_o}, 32'h0);
        chk("iff.t7.hold", if_data_o, 32'h00000013);

        // SB to 0x100
        mem_w_req_i = 1'b1; mem_addr_i = 32'h100; mem_w_data_i = 32'hAABBCCDD;
        mem_buffer_pointer_i = 4'd3;
        tick();
        chk("sb.a", ram_a_o, 32'h100);
        chk("sb.do", {24'd0, ram_dout_o}, 32'hDD);
        chk("sb.wr", {31'd0, ram_wr_o}, 32'h1);
        tick();
        chk("sb.done", {31'd0, mem_done_o}, 32'h1);
        chk("sb.wr_off", {31'd0, ram_wr_o}, 32'h0);
        mem_w_req_i = 1'b0;
        tick();
        chk("sb.done_off", {31'd0, mem_done_o}, 32'h0);
        chk("sb.ram101", {24'd0, ram[257]}, 32'h0);

        // SW to 0x200
        mem_w_req_i = 1'b1; mem_addr_i = 32'h200; mem_w_data_i = 32'h11223344;
        mem_buffer_pointer_i = 4'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sw.a", ram_a_o, 32'h200 + 32'(k));
            chk("sw.do", {24'd0, ram_dout_o}, 32'(8'h44 - 8'(k * 8'h11)));
            chk("sw.wr", {31'd0, ram_wr_o}, 32'h1);
            chk("sw.done_early", {31'd0, mem_done_o}, 32'h0);
        end
        tick();
        chk("sw.done", {31'd0, mem_done_o}, 32'h1);
        mem_w_req_i = 1'b0;
        tick();
        chk("sw.ram", {ram[515], ram[514], ram[513], ram[512]}, 32'h11223344);

        // SH to 0x300
        mem_w_req_i = 1'b1; mem_addr_i = 32'h300; mem_w_data_i = 32'hAABBCCDD;
        mem_buffer_pointer_i = 4'd2;
        tick();
        chk("sh.b0", {ram_a_o[15:0], 8'h00, ram_dout_o}, 32'h030000DD);
        tick();
        chk("sh.b1", {ram_a_o[15:0], 8'h00, ram_dout_o}, 32'h030100CC);
        chk("sh.done_early", {31'd0, mem_done_o}, 32'h0);
        tick();
        chk("sh.done", {31'd0, mem_done_o}, 32'h1);
        chk("sh.wr_off", {31'd0, ram_wr_o}, 32'h0);
        mem_w_req_i = 1'b0;
        tick();
        chk("sh.ram302", {24'd0, ram[770]}, 32'h0);

        // Address wrap on SH at 0xFFFFFFFF
        mem_w_req_i = 1'b1; mem_addr_i = 32'hFFFFFFFF; mem_w_data_i = 32'h00005A6B;
        mem_buffer_pointer_i = 4'd2;
        tick();
        chk("wrap.a0", ram_a_o, 32'hFFFFFFFF);
        tick();
        chk("wrap.a1", ram_a_o, 32'h0);
        chk("wrap.do1", {24'd0, ram_dout_o}, 32'h5A);
        tick();
        chk("wrap.done", {31'd0, mem_done_o}, 32'h1);
        mem_w_req_i = 1'b0;
        tick();

        // Simultaneous IF and MEM load: MEM first
        if_req_i = 1'b1; if_addr_i = 32'h20;
        mem_r_req_i = 1'b1; mem_addr_i = 32'h10;
        tick();
        chk("arb.a", ram_a_o, 32'h10);
        for (int k = 0; k < 4; k++) tick();
        chk("arb.t5.done", {31'd0, mem_done_o}, 32'h0);
        tick();
        chk("arb.memdone", {31'd0, mem_done_o}, 32'h1);
        chk("arb.memdata", mem_r_data_o, 32'hDEADBEEF);
        chk("arb.ifdone", {31'd0, if_done_o}, 32'h0);
        mem_r_req_i = 1'b0;
        tick();
        chk_idle_bus("arb.noreaccept");
        tick();
        chk("arb.if_a0", ram_a_o, 32'h20);
        for (int k = 0; k < 5; k++) tick();
        chk("arb.if_done", {31'd0, if_done_o}, 32'h1);
        chk("arb.if_data", if_data_o, 32'h00500093);
        chk("arb.mem_hold", mem_r_data_o, 32'hDEADBEEF);
        if_req_i = 1'b0;
        tick();

        // IF fetch aborted at T+3
        if_req_i = 1'b1; if_addr_i = 32'h4;
        tick(); tick(); tick();
        if_req_i = 1'b0;
        tick();
        chk_idle_bus("abort");
        for (int i = 0; i < 6; i++) begin
            chk("abort.ifdone", {31'd0, if_done_o}, 32'h0);
            tick();
        end
        chk("abort.hold", if_data_o, 32'h00500093);

        // Reset at T+2 of SW to 0x100
        mem_w_req_i = 1'b1; mem_addr_i = 32'h100; mem_w_data_i = 32'hCAFEF00D;
        mem_buffer_pointer_i = 4'd0;
        tick(); tick();
        rst = 1'b1; mem_w_req_i = 1'b0;
        tick();
        chk_idle_bus("rstmid");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rstmid.memdone", {31'd0, mem_done_o}, 32'h0);
            chk("rstmid.wr", {31'd0, ram_wr_o}, 32'h0);
        end
        chk("rstmid.partial", {ram[259], ram[258], ram[257], ram[256]}, 32'h0000F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
